// File: rtl/nic8_pkg.sv
// rtl/nic8_pkg.sv - shared types and constants for the program loader
// Frame and serial-receiver state encodings plus bus widths.
package nic8_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_SYNC, LEN, DATA, WRITE, VERIFY, CSUM, DONE, FAIL
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 serial byte receiver with input synchroniser
// Samples each bit at its centre; byte_valid_o / frame_err_o are one-cycle pulses.
module uart_rx_byte
  import nic8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e         state_q, state_d;
  logic              rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d, ferr_q, ferr_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: if (!rx_sync_q) begin
        state_d = RX_START;
        cnt_d   = '0;
      end
      // a start bit that is high again at mid-bit was a glitch
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RX_STOP: if (cnt_q == LAST) begin
        valid_d = rx_sync_q;
        ferr_d  = !rx_sync_q;
        state_d = RX_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads the program RAM from a serial frame, then releases the CPU
// Define PROG_LOADER_VERIFY_EN to read back and compare every written byte.
module prog_loader
  import nic8_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 16,
  parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [DATA_W-1:0] mbus,
  output logic [ADDR_W-1:0] abus,
  output logic [DATA_W-1:0] dbus,
  output logic              storeMem,
  output logic              busDrive,
  output logic              holdCpu,
  output logic              done,
  output logic              error
);

  frame_state_e      state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sum_q, sum_d, data_q, data_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] rx_byte;
  logic              rx_valid, rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clk),
    .reset_i      (reset),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SYNC;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    data_d  = data_q;
    error_d = error_q;
    if (rx_ferr && state_q != WAIT_SYNC && state_q != DONE) begin
      state_d = FAIL;
      error_d = 1'b1;
    end else begin
      unique case (state_q)
        WAIT_SYNC, FAIL: if (rx_valid && rx_byte == SYNC_BYTE) state_d = LEN;
        // length byte 0 encodes a full 256-byte image
        LEN: if (rx_valid) begin
          cnt_d   = {rx_byte == '0, rx_byte};
          addr_d  = '0;
          sum_d   = '0;
          state_d = DATA;
        end
        DATA: if (rx_valid) begin
          data_d  = rx_byte;
          sum_d   = sum_q + rx_byte;
          state_d = WRITE;
        end
        WRITE: begin
          cnt_d = cnt_q - 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
          state_d = VERIFY;
`else
          addr_d  = addr_q + 1'b1;
          state_d = (cnt_q == (ADDR_W+1)'(1)) ? CSUM : DATA;
`endif
        end
        VERIFY: begin
`ifdef PROG_LOADER_VERIFY_EN
          if (mbus != data_q) begin
            state_d = FAIL;
            error_d = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = (cnt_q == '0) ? CSUM : DATA;
          end
`else
          state_d = FAIL;
          error_d = 1'b1;
`endif
        end
        CSUM: if (rx_valid) begin
          if (rx_byte == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = FAIL;
            error_d = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

`ifndef PROG_LOADER_VERIFY_EN
  logic unused_mbus;
  assign unused_mbus = ^mbus;
`endif

  assign abus     = addr_q;
  assign storeMem = (state_q == WRITE);
  assign busDrive = (state_q inside {LEN, DATA, WRITE, VERIFY, CSUM});
  assign holdCpu  = (state_q != DONE);
  assign done     = (state_q == DONE);
  assign error    = error_q;
  assign dbus     = busDrive ? data_q : {DATA_W{1'bz}};

endmodule
